capture_threshold_trig_ctrl: RTL and testbench
==============================================

// Module: capture_threshold_trig_ctrl
// PURPOSE
//  Threshold-triggered snapshot sequencer in the user_clk domain. Compares |I|+|Q| of the
//  channelizer sample stream with the software threshold register and sequences the BRAM
//  write port of the capture snapshot: arm, wait for trigger, write a burst, report done.
//  Sits between the threshold/control software registers and the snapshot BRAM.
// PARAMETERS
//  DW        16    signed width of din_i / din_q
//  AW        10    snapshot BRAM address width
//  CAP_LEN   1024  samples written per capture, 1..2^AW
//  POST_LEN  768   samples written after trigger when PRETRIG_EN, 1..2^AW-1
// PORTS
//  user_clk    in   1      sole clock
//  user_rst_n  in   1      asynchronous active-low reset
//  threshold   in   32     software reg; [DW:0] = level (unsigned), upper bits ignored
//  ctrl        in   32     software reg; [0] arm (rising edge), [1] force trigger, [2] abort
//  din_valid   in   1      sample strobe
//  din_i       in   DW     I sample, signed
//  din_q       in   DW     Q sample, signed
//  bram_we     out  1      snapshot write enable
//  bram_addr   out  AW     snapshot write address
//  bram_data   out  2*DW   {I,Q} of written sample
//  busy        out  1      high in ARMED or CAPTURE
//  done        out  1      high in DONE
//  trig_addr   out  AW     BRAM address of trigger sample
//  trig_count  out  16     triggers since reset, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, pipeline valid 0, arm-edge detector history 0.
//  - Stage 1 (1 cycle): register din_*, din_valid; mag = |I|+|Q|, DW+1 bits unsigned;
//    |-2^(DW-1)| = 2^(DW-1), no saturation needed. FSM acts on stage 1.
//  - Stage 2: bram_we/addr/data registered from FSM decision; input-to-write latency 2 cycles.
//  - hit = s1_valid & (mag > threshold[DW:0]) (strict) | (s1_valid & ctrl[1] & ARMED).
//  - IDLE: arm rising edge -> ARMED. DONE: arm rising edge -> ARMED, done cleared.
//  - ARMED: hit -> CAPTURE; trigger sample is written at addr 0; trig_addr <= 0;
//    trig_count++ (saturating). No trigger is evaluated in the cycle the arm edge is seen.
//  - CAPTURE: each s1_valid sample written, addr increments; after CAP_LEN writes -> DONE.
//    Samples without s1_valid: bram_we 0, addr held. Arm edges ignored in CAPTURE.
//  - abort (ctrl[2] high, level): any state -> IDLE next cycle, bram_we 0, done 0,
//    trig_addr/trig_count kept. Priority: abort > arm edge > hit.
//  - Address wraps 2^AW-1 -> 0; CAP_LEN = 2^AW fills BRAM exactly once.
//  - Outputs change only on user_clk; reset asserted mid-capture aborts immediately.
// CONFIGURATION
//  PRETRIG_CAPTURE_EN defined:
//   - ARMED writes every s1_valid sample circularly (bram_we high, addr wraps).
//   - On hit: trig_addr <= current write addr; trigger sample written there; then
//     POST_LEN further samples written -> DONE. BRAM holds 2^AW-POST_LEN-1 pre-trigger
//     samples once armed long enough; CAP_LEN unused.
//  Not defined: behaviour as above; no writes in ARMED; trig_addr always 0.
// TESTING
//  1. Reset, arm 0->1, feed I=100,Q=-50 (mag 150) with threshold 200 -> busy=1, no bram_we,
//     done=0 for 5000 cycles.
//  2. Threshold 200, armed, sample I=150,Q=-60 (mag 210) -> bram_we at addr 0 two cycles
//     later with data {150,-60}; CAP_LEN=1024 writes addr 0..1023; done=1; trig_count=1.
//  3. mag exactly 200 vs threshold 200 -> no trigger; I=-32768,Q=0 with threshold 32767
//     -> trigger (mag 32768 unsigned).
//  4. Abort asserted at write 300 of capture -> next cycle bram_we=0, busy=0, done=0;
//     re-arm + force trigger -> new capture from addr 0, trig_count=2.
//  5. din_valid 1-in-3 during CAPTURE -> exactly 1024 writes, addresses contiguous,
//     arm edges mid-capture ignored.
//  6. PRETRIG_CAPTURE_EN, AW=10, POST_LEN=768: arm, 2000 sub-threshold samples, trigger
//     when addr=975 -> trig_addr=975, last write addr 719 (975+768 mod 1024), done=1.

Source files
------------

// File: rtl/capture_threshold_trig_ctrl.sv
// Threshold-triggered snapshot sequencer: arms, waits for |I|+|Q| > level, writes a BRAM burst.
// Define PRETRIG_CAPTURE_EN to write circularly while armed and keep pre-trigger history.
module capture_threshold_trig_ctrl #(
    parameter int DW       = 16,
    parameter int AW       = 10,
    parameter int CAP_LEN  = 1024,
    parameter int POST_LEN = 768
) (
    input  logic                 user_clk,
    input  logic                 user_rst_n,
    input  logic [31:0]          threshold,
    input  logic [31:0]          ctrl,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    output logic                 bram_we,
    output logic [AW-1:0]        bram_addr,
    output logic [2*DW-1:0]      bram_data,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        trig_addr,
    output logic [15:0]          trig_count
);

    // Writes still owed after the trigger sample itself has been written.
`ifdef PRETRIG_CAPTURE_EN
    localparam int POST_WR = POST_LEN;
`else
    localparam int POST_WR = CAP_LEN - 1;
`endif
    localparam logic [AW:0]   POST_CNT = (AW+1)'(POST_WR);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [DW:0]   MAG_ONE  = (DW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;
    state_t state_q, state_d;

    logic            arm_prev_q;
    logic            s1_valid_q;
    logic [DW-1:0]   s1_i_q, s1_q_q;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [AW:0]     wcnt_q, wcnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2*DW-1:0] data_q, data_d;
    logic [AW-1:0]   taddr_q, taddr_d;
    logic [15:0]     tcnt_q, tcnt_d;

    logic            arm_edge, abort, hit, wr_en;
    logic [DW:0]     i_ext, q_ext, abs_i, abs_q, mag;
    logic            unused_bits;

    assign unused_bits = ^{threshold[31:DW+1], ctrl[31:3]};

    // One extra bit holds |-2^(DW-1)| and the full sum without saturation.
    assign i_ext    = {s1_i_q[DW-1], s1_i_q};
    assign q_ext    = {s1_q_q[DW-1], s1_q_q};
    assign abs_i    = s1_i_q[DW-1] ? (~i_ext + MAG_ONE) : i_ext;
    assign abs_q    = s1_q_q[DW-1] ? (~q_ext + MAG_ONE) : q_ext;
    assign mag      = abs_i + abs_q;

    assign arm_edge = ctrl[0] & ~arm_prev_q;
    assign abort    = ctrl[2];
    assign hit      = s1_valid_q & ((mag > threshold[DW:0]) | (ctrl[1] & (state_q == S_ARMED)));

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            arm_prev_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
        end else begin
            arm_prev_q <= ctrl[0];
            s1_valid_q <= din_valid;
            s1_i_q     <= din_i;
            s1_q_q     <= din_q;
        end
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            wcnt_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            taddr_q   <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wcnt_q    <= wcnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            taddr_q   <= taddr_d;
            tcnt_q    <= tcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wcnt_d    = wcnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        taddr_d   = taddr_q;
        tcnt_d    = tcnt_q;
        wr_en     = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_edge) begin
                        state_d   = S_ARMED;
                        wr_addr_d = '0;
                    end
                end
                S_ARMED: begin
                    if (arm_edge) begin
                        wr_addr_d = '0;
                    end else if (hit) begin
                        wr_en  = 1'b1;
                        wcnt_d = '0;
`ifdef PRETRIG_CAPTURE_EN
                        taddr_d = wr_addr_q;
`else
                        taddr_d = '0;
`endif
                        if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                        state_d = (POST_CNT == '0) ? S_DONE : S_CAPTURE;
                    end
`ifdef PRETRIG_CAPTURE_EN
                    else if (s1_valid_q) begin
                        wr_en = 1'b1;
                    end
`endif
                end
                S_CAPTURE: begin
                    if (s1_valid_q) begin
                        wr_en  = 1'b1;
                        wcnt_d = wcnt_q + CNT_ONE;
                        if (wcnt_d == POST_CNT) state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (wr_en) begin
            we_d      = 1'b1;
            addr_d    = wr_addr_q;
            data_d    = {s1_i_q, s1_q_q};
            wr_addr_d = wr_addr_q + ADDR_ONE;
        end
    end

    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_data  = data_q;
    assign busy       = (state_q == S_ARMED) | (state_q == S_CAPTURE);
    assign done       = (state_q == S_DONE);
    assign trig_addr  = taddr_q;
    assign trig_count = tcnt_q;

endmodule

// File: tb/tb_capture_threshold_trig_ctrl.sv
// Randomised bench for capture_threshold_trig_ctrl against a behavioural snapshot model.
module tb_capture_threshold_trig_ctrl;
    localparam int DW = 16, AW = 10, CAP_LEN = 1024, POST_LEN = 768, DEPTH = 1 << AW;
`ifdef PRETRIG_CAPTURE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif
    localparam int AFTER_TRIG = PRE ? POST_LEN : CAP_LEN - 1;

    logic                 user_clk = 1'b0, user_rst_n = 1'b0;
    logic [31:0]          threshold = '0, ctrl = '0;
    logic                 din_valid = 1'b0;
    logic signed [DW-1:0] din_i = '0, din_q = '0;
    logic                 bram_we, busy, done;
    logic [AW-1:0]        bram_addr, trig_addr;
    logic [2*DW-1:0]      bram_data;
    logic [15:0]          trig_count;

    int checks = 0, failures = 0;
    int wlog[$];

    always #5 user_clk = ~user_clk;

    capture_threshold_trig_ctrl #(.DW(DW), .AW(AW), .CAP_LEN(CAP_LEN), .POST_LEN(POST_LEN)) dut (
        .user_clk(user_clk), .user_rst_n(user_rst_n), .threshold(threshold), .ctrl(ctrl),
        .din_valid(din_valid), .din_i(din_i), .din_q(din_q), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_data(bram_data), .busy(busy), .done(done),
        .trig_addr(trig_addr), .trig_count(trig_count)
    );

    // Model: mode 0 idle, 1 armed, 2 capture, 3 done; sample seen one cycle after input.
    int          m_mode = 0, m_next = 0, m_left = 0, m_addr = 0, m_taddr = 0, m_tcnt = 0;
    bit          m_we = 0, m_arm_hist = 0, p_valid = 0;
    int          p_i = 0, p_q = 0;
    logic [31:0] m_data = '0;

    always @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            m_mode <= 0; m_next <= 0; m_left <= 0; m_addr <= 0; m_taddr <= 0; m_tcnt <= 0;
            m_we <= 0; m_arm_hist <= 0; p_valid <= 0; p_i <= 0; p_q <= 0; m_data <= '0;
        end else begin : model_step
            int mode, nxt, left, addr, ta, tc, mag, thr;
            bit we, arm_edge, trig;
            logic [31:0] data;
            mode = m_mode; nxt = m_next; left = m_left; addr = m_addr;
            ta = m_taddr; tc = m_tcnt; data = m_data; we = 0;
            arm_edge = ctrl[0] && !m_arm_hist;
            thr  = int'(threshold & 32'h0001_FFFF);
            mag  = (p_i < 0 ? -p_i : p_i) + (p_q < 0 ? -p_q : p_q);
            trig = p_valid && ((mag > thr) || ctrl[1]);
            if (ctrl[2]) mode = 0;
            else if (mode == 0 || mode == 3) begin
                if (arm_edge) begin mode = 1; nxt = 0; end
            end else if (mode == 1) begin
                if (arm_edge) nxt = 0;
                else if (trig) begin
                    we = 1; addr = nxt; ta = PRE ? nxt : 0; nxt = (nxt + 1) % DEPTH;
                    tc = (tc < 65535) ? tc + 1 : tc;
                    left = AFTER_TRIG; mode = (left == 0) ? 3 : 2;
                end else if (PRE && p_valid) begin
                    we = 1; addr = nxt; nxt = (nxt + 1) % DEPTH;
                end
            end else if (p_valid) begin
                we = 1; addr = nxt; nxt = (nxt + 1) % DEPTH; left--;
                if (left == 0) mode = 3;
            end
            if (we) data = {p_i[15:0], p_q[15:0]};
            m_mode <= mode; m_next <= nxt; m_left <= left; m_addr <= addr;
            m_taddr <= ta; m_tcnt <= tc; m_we <= we; m_data <= data;
            m_arm_hist <= ctrl[0]; p_valid <= din_valid; p_i <= din_i; p_q <= din_q;
        end
    end

    always @(negedge user_clk) begin : compare
        logic [63:0] act, expv;
        act  = {bram_we, bram_addr, busy, done, trig_addr, trig_count};
        expv = {m_we, AW'(m_addr), (m_mode == 1 || m_mode == 2), (m_mode == 3), AW'(m_taddr), 16'(m_tcnt)};
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL outputs t=%0t got={we,addr,busy,done,taddr,tcnt}=%h expected %h", $time, act, expv);
        end
        if (m_we && bram_we) begin
            checks++;
            if (bram_data !== m_data) begin
                failures++;
                $display("FAIL bram_data t=%0t got=%h expected %h", $time, bram_data, m_data);
            end
        end
        if (bram_we) wlog.push_back(int'(bram_addr));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic cyc();
        @(posedge user_clk); #1;
    endtask

    task automatic feed(input bit v, input int i, input int q);
        din_valid = v; din_i = DW'(i); din_q = DW'(q);
        cyc();
    endtask

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic rearm();
        ctrl[0] = 1'b0; feed(0, 0, 0);
        ctrl[0] = 1'b1; feed(0, 0, 0);
    endtask

    task automatic run_until_done(input int budget, input int vmod, input bit toggle_arm);
        int n = 0;
        while (!done && n < budget) begin
            if (toggle_arm && (n % 50 == 25)) ctrl[0] = ~ctrl[0];
            feed((n % vmod) == 0, rnd(-32768, 32767), rnd(-32768, 32767));
            n++;
        end
        chk("done_within_budget", done, 1);
        @(negedge user_clk); #1;
    endtask

    task automatic check_burst(input string tag, input int base, input int exp_n,
                               input int exp_first, input int exp_last);
        int n;
        bit ok;
        n  = wlog.size() - base;
        ok = 1;
        chk({tag, "_count"}, n, exp_n);
        if (n > 0) begin
            chk({tag, "_first"}, wlog[base], exp_first);
            chk({tag, "_last"}, wlog[wlog.size() - 1], exp_last);
            for (int k = base + 1; k < wlog.size(); k++)
                if (wlog[k] != (wlog[k-1] + 1) % DEPTH) ok = 0;
            chk({tag, "_contiguous"}, ok, 1);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, tc0, n;
        repeat (3) cyc();
        chk("reset_we", bram_we, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_tcount", trig_count, 0);
        chk("reset_addr", {bram_addr, trig_addr, bram_data}, 0);
        user_rst_n = 1'b1;
        cyc();

`ifndef PRETRIG_CAPTURE_EN
        // Sub-threshold traffic never triggers.
        threshold = 32'd200;
        base = wlog.size();
        ctrl[0] = 1'b1; feed(0, 0, 0);
        for (int k = 0; k < 5000; k++)
            if (k % 7 == 0) feed(1, 100, -50);
            else feed(1, rnd(-100, 100), rnd(-100, 100));
        chk("t1_busy", busy, 1);
        chk("t1_done", done, 0);
        check_burst("t1_writes", base, 0, 0, 0);

        // Trigger sample lands at addr 0 two cycles after input.
        base = wlog.size();
        feed(1, 150, -60);
        feed(1, rnd(-300, 300), rnd(-300, 300));
        chk("t2_we", bram_we, 1);
        chk("t2_addr", bram_addr, 0);
        chk("t2_data", bram_data, 32'h0096_FFC4);
        chk("t2_tcount", trig_count, 1);
        chk("t2_model_tcount", m_tcnt, 1);
        run_until_done(4000, 1, 0);
        check_burst("t2_burst", base, CAP_LEN, 0, CAP_LEN - 1);
        chk("t2_busy_after", busy, 0);

        // Equality is not a trigger; -32768 gives magnitude 32768.
        threshold = 32'd200;
        base = wlog.size();
        rearm();
        feed(1, 150, -50); feed(1, -200, 0); feed(1, 0, 200); feed(1, -100, -100);
        threshold = 32'hFFFE_7FFF;
        feed(1, 32767, 0); feed(1, -16384, -16383); feed(0, 0, 0); feed(0, 0, 0);
        chk("t3_busy", busy, 1);
        check_burst("t3_nowrite", base, 0, 0, 0);
        feed(1, -32768, 0);
        feed(0, 0, 0);
        chk("t3_we", bram_we, 1);
        chk("t3_addr", bram_addr, 0);
        chk("t3_data", bram_data, 32'h8000_0000);
        chk("t3_tcount", trig_count, 2);
        ctrl[2] = 1'b1; feed(0, 0, 0); ctrl[2] = 1'b0;
        chk("t3_abort_idle", {bram_we, busy, done}, 0);

        // Abort mid-burst, then force-trigger a fresh capture.
        threshold = 32'd200;
        rearm();
        base = wlog.size();
        feed(1, 150, -60);
        n = 0;
        while (wlog.size() - base < 300 && n < 2000) begin feed(1, rnd(-999, 999), 7); n++; end
        chk("t4_reached_300", (wlog.size() - base) >= 300, 1);
        ctrl[2] = 1'b1; feed(1, 5, 5);
        chk("t4_abort_we", bram_we, 0);
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_tcount", trig_count, 3);
        ctrl[2] = 1'b0;
        rearm();
        ctrl[1] = 1'b1; feed(1, 1, 1); feed(0, 0, 0); ctrl[1] = 1'b0;
        chk("t4_force_we", bram_we, 1);
        chk("t4_force_addr", bram_addr, 0);
        chk("t4_force_data", bram_data, 32'h0001_0001);
        chk("t4_force_tcount", trig_count, 4);
        run_until_done(4000, 1, 0);

        // Sparse valid and arm toggling during capture.
        rearm();
        base = wlog.size();
        feed(1, 150, -60);
        run_until_done(5000, 3, 1);
        check_burst("t5_burst", base, CAP_LEN, 0, CAP_LEN - 1);
        chk("t5_tcount", trig_count, 5);
`else
        // Circular pre-trigger fill, trigger at addr 975, POST_LEN more writes.
        threshold = 32'd30000;
        rearm();
        base = wlog.size();
        for (int k = 0; k < 975 + DEPTH; k++) feed(1, rnd(-1000, 1000), rnd(-1000, 1000));
        feed(1, 20000, 20000);
        feed(0, 0, 0);
        chk("t6_trig_addr", trig_addr, 975);
        chk("t6_we_addr", {bram_we, bram_addr}, {1'b1, 10'd975});
        run_until_done(3000, 1, 0);
        check_burst("t6_burst", base, 975 + DEPTH + 1 + POST_LEN, 0, 719);
        chk("t6_trig_addr_done", trig_addr, 975);
`endif

        // Asynchronous reset in the middle of a capture.
        threshold = 32'd100;
        rearm();
        feed(1, 300, 0);
        for (int k = 0; k < 100; k++) feed(1, rnd(-500, 500), rnd(-500, 500));
        tc0 = int'(trig_count);
        chk("rst_pre_busy", busy, 1);
        user_rst_n = 1'b0; #1;
        chk("rst_mid_outputs", {bram_we, busy, done, trig_count, trig_addr, bram_addr}, 0);
        chk("rst_mid_tcount_was_set", tc0 > 0, 1);
        cyc(); cyc();
        user_rst_n = 1'b1;
        ctrl = 32'hABCD_0000;
        cyc();

        // Random phase: arm/force/abort/threshold churn, model compares every cycle.
        for (int k = 0; k < 15000; k++) begin
            if ($urandom_range(0, 39) == 0) ctrl[0] = ~ctrl[0];
            ctrl[1] = ($urandom_range(0, 63) == 0);
            ctrl[2] = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0)
                threshold = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 3000));
            if ($urandom_range(0, 99) == 0) feed(1, -32768, -32768);
            else feed($urandom_range(0, 3) != 0, rnd(-1600, 1600), rnd(-1600, 1600));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
